branch_cond_unit: RTL

- Consumer side of the C/Z/N flag register.
- On a start request it waits until no flag load is pending, then snapshots C/Z/N and evaluates a 4-bit condition code.
- It resolves the next PC, taken or fall-through, and holds the result until the controller acknowledges it.
- It keeps saturating taken/not-taken statistics.
- It sits between the flag register and the multicycle controller's PC-select path.

---
 rtl/branch_cond_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/branch_cond_unit.sv
// branch_cond_unit
//   Consumer side of the C/Z/N flag register. A start request latches a
//   condition code and two candidate PCs. The unit then waits until no flag
//   load is pending, or until the stall budget runs out, and snapshots C/Z/N.
//   It evaluates the condition and holds the resolved next PC until the
//   controller acknowledges it. It also keeps saturating statistics of taken
//   and not-taken resolutions.
//
//   State table
//     state  | meaning
//     IDLE   | waiting for start
//     WAIT   | waiting for pending flag loads to drain (bounded by MAX_STALL)
//     EVAL   | evaluate condition from the snapshot, update counters
//     DONE   | result valid, waiting for ack
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start, cond, target,
//   pc_next             : request and its operands (sampled in IDLE)
//   C, Z, N             : current flag register values
//   LdC, LdZ, LdN       : flag loads this cycle (flags change at next edge)
//   ack                 : controller consumed the result
//   busy, done          : status (busy = not IDLE, done = DONE)
//   taken, next_pc,
//   illegal, stall_err  : result, qualified by done, held until next EVAL
//   taken_cnt,
//   ntaken_cnt          : saturating resolution statistics

module branch_cond_unit #(
    parameter int AW        = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       cond,
    input  logic [AW-1:0]    target,
    input  logic [AW-1:0]    pc_next,
    input  logic             C,
    input  logic             Z,
    input  logic             N,
    input  logic             LdC,
    input  logic             LdZ,
    input  logic             LdN,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic [AW-1:0]    next_pc,
    output logic             illegal,
    output logic             stall_err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    localparam int SW = (MAX_STALL > 1) ? $clog2(MAX_STALL) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(MAX_STALL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state;
    logic [3:0]      cond_q;
    logic [AW-1:0]   target_q;
    logic [AW-1:0]   pc_next_q;
    logic            c_snap;
    logic            z_snap;
    logic            n_snap;
    logic [SW-1:0]   stall_cnt;
    logic            forced_q;
    logic            ld_any;
    logic            cond_true;
    logic            cond_legal;

    assign ld_any = LdC | LdZ | LdN;

    // Condition evaluation always works on the snapshot, never on live flags.
    always_comb begin
        cond_true  = 1'b0;
        cond_legal = 1'b1;
        case (cond_q)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = z_snap;
            4'd2:    cond_true = ~z_snap;
            4'd3:    cond_true = c_snap;
            4'd4:    cond_true = ~c_snap;
            4'd5:    cond_true = n_snap;
            4'd6:    cond_true = ~n_snap;
            4'd7:    cond_true = c_snap & ~z_snap;
            4'd8:    cond_true = ~c_snap | z_snap;
            4'd9:    cond_true = ~z_snap & ~n_snap;
            4'd10:   cond_true = z_snap | n_snap;
            default: cond_legal = 1'b0;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cond_q     <= '0;
            target_q   <= '0;
            pc_next_q  <= '0;
            c_snap     <= 1'b0;
            z_snap     <= 1'b0;
            n_snap     <= 1'b0;
            stall_cnt  <= '0;
            forced_q   <= 1'b0;
            taken      <= 1'b0;
            next_pc    <= '0;
            illegal    <= 1'b0;
            stall_err  <= 1'b0;
            taken_cnt  <= '0;
            ntaken_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cond_q    <= cond;
                        target_q  <= target;
                        pc_next_q <= pc_next;
                        stall_cnt <= '0;
                        forced_q  <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!ld_any) begin
                        c_snap <= C;
                        z_snap <= Z;
                        n_snap <= N;
                        state  <= S_EVAL;
                    end else if (stall_cnt < STALL_LAST) begin
                        stall_cnt <= stall_cnt + SW'(1);
                    end else begin
                        // Stall budget exhausted: take the flags as they are now.
                        c_snap   <= C;
                        z_snap   <= Z;
                        n_snap   <= N;
                        forced_q <= 1'b1;
                        state    <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    taken     <= cond_legal & cond_true;
                    illegal   <= ~cond_legal;
                    stall_err <= forced_q;
                    next_pc   <= (cond_legal && cond_true) ? target_q : pc_next_q;
                    if (cond_legal) begin
                        if (cond_true) begin
                            if (taken_cnt != '1)
                                taken_cnt <= taken_cnt + CNT_W'(1);
                        end else begin
                            if (ntaken_cnt != '1)
                                ntaken_cnt <= ntaken_cnt + CNT_W'(1);
                        end
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    // A start coinciding with ack is dropped; IDLE must see it afresh.
                    if (ack)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
